// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg
// Purpose : default build constants for the input conditioner and a helper
//           that sizes a counter so it can hold a given maximum value
//           without wrapping.
// Contents: NCH_DEF, DB_CYCLES_DEF, STRETCH_DEF, LP_CYCLES_DEF, cnt_width().
package input_conditioner_pkg;

  localparam int NCH_DEF       = 4;
  localparam int DB_CYCLES_DEF = 4;
  localparam int STRETCH_DEF   = 7;
  localparam int LP_CYCLES_DEF = 16;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// input_conditioner_ch
// Purpose : one conditioner channel. Synchronises, debounces, detects edges,
//           stretches rising edges and (optionally) flags a long press.
// Ports   : clk        - clock, rising edge
//           rst        - asynchronous reset, active low
//           clr        - synchronous clear of channel state (synchroniser kept)
//           in         - raw asynchronous input
//           level      - debounced level
//           rise/fall  - one-cycle pulses on accepted level changes
//           stretched  - rise held for STRETCH cycles, retriggerable
//           long_press - one-cycle pulse after LP_CYCLES of level high
// Macro   : INPUT_CONDITIONER_LONG_PRESS_EN builds the long-press logic/port.
module input_conditioner_ch
  import input_conditioner_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int STRETCH   = STRETCH_DEF
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
  , parameter int LP_CYCLES = LP_CYCLES_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic stretched
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
  , output logic long_press
`endif
);

  localparam int DB_W = cnt_width(DB_CYCLES);
  localparam int ST_W = cnt_width(STRETCH);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(STRETCH);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] db_cnt;
  logic [ST_W-1:0] st_cnt;
  logic            accept;

  // The sample that would bring the count to DB_CYCLES is the accepting one,
  // so level flips on that same edge and the latency is exactly 2+DB_CYCLES.
  assign accept = (sync2 != level) && (db_cnt == DB_LAST);

  // Synchroniser survives clr so an input already high is seen again at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      db_cnt <= '0;
    end else if (clr) begin
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      db_cnt <= '0;
    end else begin
      rise <= accept && !level;
      fall <= accept && level;
      if (sync2 == level) begin
        db_cnt <= '0;
      end else if (accept) begin
        db_cnt <= '0;
        level  <= ~level;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Loaded on the accepting edge so stretched rises together with rise;
  // a new rise reloads rather than extends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_cnt <= '0;
    end else if (clr) begin
      st_cnt <= '0;
    end else if (accept && !level) begin
      st_cnt <= ST_LOAD;
    end else if (st_cnt != '0) begin
      st_cnt <= st_cnt - ST_W'(1);
    end
  end

  assign stretched = (st_cnt != '0);

`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
  localparam int LP_W = cnt_width(LP_CYCLES);
  localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LP_CYCLES);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LP_CYCLES - 1);

  logic [LP_W-1:0] lp_cnt;

  // Saturates at LP_CYCLES so the pulse fires once per press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lp_cnt     <= '0;
      long_press <= 1'b0;
    end else if (clr || !level) begin
      lp_cnt     <= '0;
      long_press <= 1'b0;
    end else if (lp_cnt != LP_MAX) begin
      lp_cnt     <= lp_cnt + LP_W'(1);
      long_press <= (lp_cnt == LP_LAST);
    end else begin
      long_press <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner
// Purpose : NCH independent input conditioner channels (synchronise,
//           debounce, edge detect, pulse stretch, optional long press).
// Ports   : clk        - clock, rising edge
//           rst        - asynchronous reset, active low
//           clr        - synchronous clear of all channel state
//           in         - raw asynchronous inputs [NCH]
//           level      - debounced levels [NCH]
//           rise/fall  - accepted edge pulses [NCH]
//           stretched  - stretched rise pulses [NCH]
//           long_press - long-press pulses [NCH] (macro builds only)
// Macro   : INPUT_CONDITIONER_LONG_PRESS_EN adds long_press and LP_CYCLES.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int NCH       = NCH_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int STRETCH   = STRETCH_DEF
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
  , parameter int LP_CYCLES = LP_CYCLES_DEF
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic [NCH-1:0] in,
  output logic [NCH-1:0] level,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall,
  output logic [NCH-1:0] stretched
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
  , output logic [NCH-1:0] long_press
`endif
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    input_conditioner_ch #(
      .DB_CYCLES (DB_CYCLES),
      .STRETCH   (STRETCH)
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
      , .LP_CYCLES (LP_CYCLES)
`endif
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .in         (in[i]),
      .level      (level[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .stretched  (stretched[i])
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
      , .long_press (long_press[i])
`endif
    );
  end

endmodule
